// File: rtl/hilo_div_seq.sv
// Iterative restoring divider for MIPS DIV/DIVU.
// Produces {HI,LO} = {remainder, quotient} after one quotient bit per cycle.
module hilo_div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [2*DATA_W-1:0]   result_o
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_next;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   dvd;
    logic [DATA_W-1:0]   dvs;
    logic                neg_quo, neg_rem;

    logic                launch, div_zero;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     shifted, diff;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign launch   = start_i && !annul_i;
    assign div_zero = (opdata2_i == '0);

    // Magnitudes stay DATA_W-bit unsigned, so |-2^(W-1)| is representable.
    assign abs1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign abs2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    assign shifted = {rem, dvd[DATA_W-1]};
    assign diff    = shifted - {1'b0, dvs};

    assign quo_fix  = neg_quo ? -dvd : dvd;
    assign rem_fix  = neg_rem ? -rem : rem;
    assign result_o = ready_o ? {rem_fix, quo_fix} : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        ready_o    = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_next = div_zero ? DONE : BUSY;
            end
            BUSY: begin
                busy_o = 1'b1;
                if (annul_i || !start_i) state_next = IDLE;
                else if (count == LAST)  state_next = DONE;
            end
            DONE: begin
                ready_o = 1'b1;
                if (annul_i || !start_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // dvd shifts the dividend out MSB first while quotient bits shift in behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rem     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        count <= '0;
                        rem   <= '0;
                        if (div_zero) begin
                            dvd     <= '0;
                            dvs     <= '0;
                            neg_quo <= 1'b0;
                            neg_rem <= 1'b0;
                        end else begin
                            dvd     <= abs1;
                            dvs     <= abs2;
                            neg_quo <= signed_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                            neg_rem <= signed_i && opdata1_i[DATA_W-1];
                        end
                    end
                end
                BUSY: begin
                    count <= count + CW'(1);
                    rem   <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
                    dvd   <= {dvd[DATA_W-2:0], ~diff[DATA_W]};
                end
                default: ;
            endcase
        end
    end

endmodule
